cache_rd_stream: RTL and testbench
==================================

Name: cache_rd_stream

Overview:
- Read sequencer directly downstream of the dual-port cache RAM.
- On a start command it issues a burst of consecutive read addresses on the RAM read port (addrb).
- It absorbs the RAM's fixed 1-cycle read latency and delivers the words as a valid/ready stream to the consumer.
- Backpressure is handled with a 2-entry buffer, so no word is lost or duplicated. Full throughput is one word per cycle when m_ready is held high.

Parameters:
- DATA_WIDTH, 32, width of RAM words and stream data.
- ADDR_WIDTH, 10, width of RAM addresses; the RAM holds 2**ADDR_WIDTH words.

Ports:
- clk  input  1  single clock, shared with the RAM.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first word address; sampled with start.
- length  input  ADDR_WIDTH+1  number of words, 0 to 2**ADDR_WIDTH; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse after the last word handshakes.
- addrb  output  ADDR_WIDTH  RAM read address, registered.
- doutb  input  DATA_WIDTH  RAM read data; valid the cycle after an address is presented.
- m_data  output  DATA_WIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from the consumer.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; addrb, m_data, m_valid, busy, done all 0.
  - Buffer emptied; pending flag cleared; counters cleared.
- Reset mid-burst aborts the burst: no done pulse, and the remaining words are discarded.
- States:
  - IDLE: start=1 with length>0 → RUN; latch base_addr and length; issue counter := 0; delivered counter := 0. start=1 with length=0 → DONE, with no RAM reads. start=0 → stay in IDLE.
  - RUN: issue reads per the credit rule below. When delivered count == length and the buffer is empty → DONE.
  - DONE: assert done for exactly one cycle, deassert busy → IDLE.
- busy = (state != IDLE). start is ignored while busy=1.
- Issue and credit rule:
  - A read issues in a cycle when issued < length and (buf_count + pending − pop) < 2, where pop = m_valid & m_ready.
  - On issue: the registered address is driven on addrb, and pending is set for the next cycle.
  - addrb = (base_addr + issued) mod 2**ADDR_WIDTH, so it wraps from the top address to 0.
  - addrb holds its last value when no read issues.
- Capture: in a cycle with pending=1, doutb is written into the buffer at the clock edge. The buffer can never overflow, by the credit rule.
- Output:
  - m_valid = (buf_count > 0); m_data = buffer head, registered.
  - m_data stays stable while m_valid=1 and m_ready=0.
  - A pop and a push in the same cycle are both honoured.
- Latency:
  - start accepted in cycle 0 → first addrb issued in cycle 1 → doutb in cycle 2 → m_valid=1 in cycle 3.
  - With m_ready held at 1: one word per cycle; last word handshakes in cycle length+2; done in cycle length+3.
- Counters are ADDR_WIDTH+1 bits so that length = 2**ADDR_WIDTH completes.

Decomposition:
- Package cache_rd_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Constant BUF_DEPTH=2.
  - Count-width localparam derived from ADDR_WIDTH.
- Sub-module rd_skid_fifo: 2-entry synchronous FIFO (push, pop, head data, count), parameterised by DATA_WIDTH and reset by rst.

Test Plan:
(RAM model preloaded with ram[a] = a + 32'h1000; 1-cycle read latency.)
1. base=5, length=4, m_ready=1 constantly → words 0x1005..0x1008 on m_valid in cycles 3..6; done pulse in cycle 7; busy high in cycles 1..7.
2. base=1022, length=4 → addrb sequence 1022, 1023, 0, 1; data 0x13FE, 0x13FF, 0x1000, 0x1001.
3. base=0, length=8, m_ready toggles 1,0,0,1,… plus random stalls → exactly 0x1000..0x1007 in order; no duplicates or drops; m_data stable while stalled; the number of words in flight never exceeds 2.
4. length=0 → done pulses in cycle 1; addrb unchanged; m_valid never asserts.
5. A second start pulse while busy → ignored; only the original burst is delivered; one done pulse.
6. rst asserted after 2 words of a length-6 burst → all outputs 0 immediately (asynchronously); no done; a new start (base=10, length=2) afterwards → 0x100A, 0x100B delivered normally.

Source files
------------

// File: rtl/cache_rd_pkg.sv
// Shared types and constants for the cache read-stream sequencer.
// The counter width is one bit wider than the address, so a full-RAM burst still fits.
package cache_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BUF_DEPTH      = 2;
    localparam int DEF_ADDR_WIDTH = 10;

    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int DEF_CNT_WIDTH = cnt_width(DEF_ADDR_WIDTH);

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry synchronous FIFO that absorbs consumer backpressure behind the RAM.
// The head word comes straight from a storage register, so stream data is registered.
module rd_skid_fifo
    import cache_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
    logic                  wr_ptr_r;
    logic                  rd_ptr_r;
    logic [1:0]            count_r;

    // Storage, pointers and occupancy; a push and a pop in one cycle are both honoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/cache_rd_stream.sv
// Burst read sequencer: walks consecutive RAM addresses, hides the 1-cycle read
// latency and delivers the words as a valid/ready stream through a 2-entry buffer.
module cache_rd_stream
    import cache_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_r;
    state_t                state_nx;
    logic [CW-1:0]         len_r;
    logic [CW-1:0]         issued_r;
    logic [CW-1:0]         delivered_r;
    logic [ADDR_WIDTH-1:0] addrb_r;
    logic                  pending_r;
    logic [1:0]            buf_count_s;
    logic                  pop_s;
    logic [2:0]            occ_s;
    logic                  issue_s;
    logic [CW-1:0]         issued_inc_s;
    logic [CW-1:0]         delivered_nx_s;

    rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (pending_r),
        .push_data (doutb),
        .pop       (pop_s),
        .head      (m_data),
        .count     (buf_count_s)
    );

    // Credit check: the word read now must still find room once the in-flight one lands.
    always_comb begin
        pop_s          = m_valid & m_ready;
        occ_s          = {1'b0, buf_count_s} + {2'b00, pending_r} - {2'b00, pop_s};
        issued_inc_s   = issued_r + CNT_ONE;
        delivered_nx_s = delivered_r + {{(CW-1){1'b0}}, pop_s};
        if ((state_r == RUN) && (issued_r < len_r) && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; RUN ends on the edge where the final word handshakes.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx = (length == '0) ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (delivered_nx_s == len_r) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RUN;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from the state register.
    always_comb begin
        busy    = (state_r != IDLE);
        done    = (state_r == DONE);
        m_valid = (buf_count_s != 2'd0);
        addrb   = addrb_r;
    end

    // Burst bookkeeping; addrb always shows the address of the next (or last) read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r       <= '0;
            issued_r    <= '0;
            delivered_r <= '0;
            addrb_r     <= '0;
            pending_r   <= 1'b0;
        end else begin
            pending_r <= issue_s;
            if ((state_r == IDLE) && start) begin
                len_r       <= length;
                issued_r    <= '0;
                delivered_r <= '0;
                if (length != '0) begin
                    addrb_r <= base_addr;
                end
            end else begin
                if (issue_s) begin
                    issued_r <= issued_inc_s;
                    if (issued_inc_s < len_r) begin
                        addrb_r <= addrb_r + ADDR_ONE;
                    end
                end
                if (pop_s) begin
                    delivered_r <= delivered_nx_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_rd_stream.sv
// Directed bench for cache_rd_stream: table of bursts plus hand-written corner sequences.
// RAM model: ram[a] = a + 0x1000 with a 1-cycle registered read.
module tb_cache_rd_stream;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    cache_rd_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) doutb <= 32'h0000_1000 + {22'd0, addrb};

    typedef struct {
        logic [AW-1:0] base;
        logic [AW:0]   len;
        int            mode;
        int            exp_first;
        int            exp_done;
        logic [31:0]   exp_w0;
        logic [31:0]   exp_wl;
    } vec_t;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [31:0]   got[$];
    logic [AW-1:0] addr_seen[$];
    int            done_cyc, first_cyc, busy_cnt, done_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1 with random extra stalls
    task automatic run_burst(input logic [AW-1:0] b, input logic [AW:0] len,
                             input int mode, input int extra_start);
        logic          stalled = 1'b0;
        logic [31:0]   stall_data = 32'd0;
        logic [AW-1:0] last_addr = addrb;
        int            budget = int'(len) + 60;
        got.delete();
        addr_seen.delete();
        done_cyc = -1; first_cyc = -1; busy_cnt = 0; done_cnt = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            start     = (c == 0) || (c == extra_start);
            base_addr = (c == extra_start) ? b + 10'd7 : b;
            length    = (c == extra_start) ? 11'd3 : len;
            if (mode == 0) m_ready = 1'b1;
            else m_ready = ((c % 4 == 0) || (c % 4 == 3)) && ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if ((c == 1 && len != 11'd0) || (c > 1 && addrb != last_addr))
                addr_seen.push_back(addrb);
            last_addr = addrb;
            if (stalled) begin
                check("stall_valid", {31'd0, m_valid}, 32'd1);
                check("stall_data", m_data, stall_data);
            end
            if (m_valid && first_cyc < 0) first_cyc = c;
            if (m_valid && m_ready) got.push_back(m_data);
            stalled    = m_valid && !m_ready;
            stall_data = m_data;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0;
        check("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    endtask

    task automatic verify(input logic [AW-1:0] b, input logic [AW:0] len, input int exp_first,
                          input int exp_done, input logic [31:0] w0, input logic [31:0] wl);
        logic [AW-1:0] a;
        check("done_count", done_cnt, 32'd1);
        if (exp_done >= 0) check("done_cycle", done_cyc, exp_done);
        check("busy_cycles", busy_cnt, done_cyc);
        check("first_valid", first_cyc, exp_first);
        check("word_count", got.size(), {21'd0, len});
        for (int i = 0; i < got.size(); i++) begin
            a = b + i[AW-1:0];
            check("word", got[i], 32'h0000_1000 + {22'd0, a});
        end
        if (len != 11'd0 && got.size() > 0) begin
            check("first_word", got[0], w0);
            check("last_word", got[got.size()-1], wl);
        end
        check("addr_count", addr_seen.size(), {21'd0, len});
        for (int i = 0; i < addr_seen.size(); i++) begin
            a = b + i[AW-1:0];
            check("addrb_seq", {22'd0, addr_seen[i]}, {22'd0, a});
        end
    endtask

    vec_t vecs[7];
    logic [AW-1:0] addr_before;

    initial begin
        vecs[0] = '{10'd5,    11'd4,    0,  3,    7, 32'h1005, 32'h1008};
        vecs[1] = '{10'd1022, 11'd4,    0,  3,    7, 32'h13FE, 32'h1001};
        vecs[2] = '{10'd0,    11'd8,    1,  3,   -1, 32'h1000, 32'h1007};
        vecs[3] = '{10'd0,    11'd0,    0, -1,    1, 32'h0,    32'h0};
        vecs[4] = '{10'd1023, 11'd1,    0,  3,    4, 32'h13FF, 32'h13FF};
        vecs[5] = '{10'd700,  11'd3,    0,  3,    6, 32'h12BC, 32'h12BE};
        vecs[6] = '{10'd512,  11'd1024, 0,  3, 1027, 32'h1200, 32'h11FF};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_addrb", {22'd0, addrb}, 32'd0);
        check("rst_data", m_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            addr_before = addrb;
            run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, -1);
            verify(vecs[v].base, vecs[v].len, vecs[v].exp_first, vecs[v].exp_done,
                   vecs[v].exp_w0, vecs[v].exp_wl);
            if (vecs[v].len == 11'd0) check("len0_addrb", {22'd0, addrb}, {22'd0, addr_before});
        end

        // second start while busy must be ignored
        run_burst(10'd200, 11'd3, 0, 2);
        verify(10'd200, 11'd3, 3, 6, 32'h10C8, 32'h10CA);

        // asynchronous reset after two words of a six-word burst
        begin
            int words = 0;
            int c = 0;
            @(posedge clk); #1;
            start = 1'b1; base_addr = 10'd20; length = 11'd6; m_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            while (words < 2 && c < 20) begin
                @(negedge clk);
                if (m_valid && m_ready) words++;
                c++;
                @(posedge clk); #1;
            end
            check("pre_rst_words", words, 32'd2);
            #2;
            rst = 1'b1;
            #1;
            check("arst_busy", {31'd0, busy}, 32'd0);
            check("arst_done", {31'd0, done}, 32'd0);
            check("arst_valid", {31'd0, m_valid}, 32'd0);
            check("arst_addrb", {22'd0, addrb}, 32'd0);
            check("arst_data", m_data, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            done_cnt = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done || m_valid) done_cnt++;
            end
            check("post_rst_quiet", done_cnt, 32'd0);
        end
        run_burst(10'd10, 11'd2, 0, -1);
        verify(10'd10, 11'd2, 3, 5, 32'h100A, 32'h100B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
